// File: rtl/dm_interface_pkg.sv
// dm_interface_pkg: shared types and constants for the data-memory bridge.
//   WORD_SIZE   - data/address width (byte lanes assume 32 bits)
//   F3_*        - funct3 access size/sign codes
//   dm_state_e  - bridge FSM state encoding
//   dm_bus_req_t- registered bus request payload
package dm_interface_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned BE_W      = WORD_SIZE / 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } dm_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } dm_size_e;

    typedef struct packed {
        logic                 we;
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] wdata;
        logic [BE_W-1:0]      be;
    } dm_bus_req_t;

    // Unlisted encodings (011, 110, 111) fall through to word size.
    function automatic dm_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3_size(f3))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dm_interface_align.sv
// dm_interface_align: combinational byte-lane steering.
//   addr_lo     in  byte offset within the word
//   funct3      in  access size/sign code
//   wd          in  store data from the core
//   rdata       in  raw bus read data
//   be_c        out byte enables for the access
//   wdata_c     out lane-replicated store data
//   rdata_ext_c out selected and sign/zero-extended load data
module dm_interface_align
    import dm_interface_pkg::*;
(
    input  logic [1:0]           addr_lo,
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] wd,
    input  logic [WORD_SIZE-1:0] rdata,
    output logic [BE_W-1:0]      be_c,
    output logic [WORD_SIZE-1:0] wdata_c,
    output logic [WORD_SIZE-1:0] rdata_ext_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // funct3[2] marks the unsigned load variants.
    always_comb begin
        be_c        = '1;
        wdata_c     = wd;
        rdata_ext_c = rdata;
        case (f3_size(funct3))
            SZ_BYTE: begin
                be_c        = BE_W'(1) << addr_lo;
                wdata_c     = {4{wd[7:0]}};
                rdata_ext_c = funct3[2] ? {{(WORD_SIZE-8){1'b0}}, byte_sel}
                                        : {{(WORD_SIZE-8){byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be_c        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_c     = {2{wd[15:0]}};
                rdata_ext_c = funct3[2] ? {{(WORD_SIZE-16){1'b0}}, half_sel}
                                        : {{(WORD_SIZE-16){half_sel[15]}}, half_sel};
            end
            default: begin
                be_c        = '1;
                wdata_c     = wd;
                rdata_ext_c = rdata;
            end
        endcase
    end

endmodule

// File: rtl/dm_interface.sv
// dm_interface: bridges the core's combinational load/store port onto a
// req/gnt/rvalid word bus, stalling the core until the access completes.
//   i_clk, i_rstn          clock, async active-low reset
//   i_addr, i_wd           byte address and store data from the core
//   i_wen, i_ren, i_funct3 access request and size/sign
//   o_rd                   extended load data (registered)
//   o_stall                combinational core stall
//   o_misaligned, o_bus_err one-cycle error pulses
//   o_bus_*                registered bus request
//   i_bus_gnt, i_bus_rvalid, i_bus_rdata  bus responses
module dm_interface
    import dm_interface_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic [WORD_SIZE-1:0] i_wd,
    input  logic                 i_wen,
    input  logic                 i_ren,
    input  logic [2:0]           i_funct3,
    output logic [WORD_SIZE-1:0] o_rd,
    output logic                 o_stall,
    output logic                 o_misaligned,
    output logic                 o_bus_err,
    output logic                 o_bus_req,
    output logic                 o_bus_we,
    output logic [WORD_SIZE-1:0] o_bus_addr,
    output logic [WORD_SIZE-1:0] o_bus_wdata,
    output logic [BE_W-1:0]      o_bus_be,
    input  logic                 i_bus_gnt,
    input  logic                 i_bus_rvalid,
    input  logic [WORD_SIZE-1:0] i_bus_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    dm_state_e            state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W:0]       cnt_inc;
    logic                 timeout_hit;
    dm_bus_req_t          bus_q;
    logic                 req_any;
    logic [BE_W-1:0]      al_be;
    logic [WORD_SIZE-1:0] al_wdata;
    logic [WORD_SIZE-1:0] al_rd;

    // The core holds its request stable while stalled, so lane selection
    // for the returning load data can use the live address/funct3.
    dm_interface_align u_align (
        .addr_lo     (i_addr[1:0]),
        .funct3      (i_funct3),
        .wd          (i_wd),
        .rdata       (i_bus_rdata),
        .be_c        (al_be),
        .wdata_c     (al_wdata),
        .rdata_ext_c (al_rd)
    );

    assign req_any = i_ren | i_wen;
    assign o_stall = req_any && (state != ST_DONE);

    // Abort once the count is about to reach TIMEOUT-1 without completion.
    assign cnt_inc     = {1'b0, cnt} + (CNT_W+1)'(1);
    assign timeout_hit = (cnt_inc >= (CNT_W+1)'(TIMEOUT - 1));

    assign o_bus_we    = bus_q.we;
    assign o_bus_addr  = bus_q.addr;
    assign o_bus_wdata = bus_q.wdata;
    assign o_bus_be    = bus_q.be;

    // Bridge FSM with timeout counter and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bus_q        <= '0;
            o_rd         <= '0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            o_bus_req    <= 1'b0;
        end else begin
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (req_any) begin
                        if (is_misaligned(i_funct3, i_addr[1:0])) begin
                            o_misaligned <= 1'b1;
                            if (!i_wen) begin
                                o_rd <= '0;
                            end
                            state <= ST_DONE;
                        end else begin
                            o_bus_req   <= 1'b1;
                            bus_q.we    <= i_wen;
                            bus_q.addr  <= {i_addr[WORD_SIZE-1:2], 2'b00};
                            bus_q.wdata <= al_wdata;
                            bus_q.be    <= al_be;
                            state       <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt_inc[CNT_W-1:0];
                    if (i_bus_gnt) begin
                        o_bus_req <= 1'b0;
                        state     <= bus_q.we ? ST_DONE : ST_WAIT_R;
                    end else if (timeout_hit) begin
                        o_bus_req <= 1'b0;
                        o_bus_err <= 1'b1;
                        if (!bus_q.we) begin
                            o_rd <= '0;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_WAIT_R: begin
                    cnt <= cnt_inc[CNT_W-1:0];
                    if (i_bus_rvalid) begin
                        o_rd  <= al_rd;
                        state <= ST_DONE;
                    end else if (timeout_hit) begin
                        o_bus_err <= 1'b1;
                        o_rd      <= '0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_interface.sv
// tb_dm_interface: directed self-checking bench for dm_interface.
module tb_dm_interface;
    import dm_interface_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wd = '0;
    logic        i_wen = 1'b0;
    logic        i_ren = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] o_rd;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_bus_err;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_gnt = 1'b0;
    logic        i_bus_rvalid = 1'b0;
    logic [31:0] i_bus_rdata = '0;

    int tests = 0;
    int fails = 0;

    dm_interface #(.TIMEOUT(16)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_addr       (i_addr),
        .i_wd         (i_wd),
        .i_wen        (i_wen),
        .i_ren        (i_ren),
        .i_funct3     (i_funct3),
        .o_rd         (o_rd),
        .o_stall      (o_stall),
        .o_misaligned (o_misaligned),
        .o_bus_err    (o_bus_err),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_be     (o_bus_be),
        .i_bus_gnt    (i_bus_gnt),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Store with gnt in the first REQ cycle: IDLE, REQ, DONE.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
        @(negedge i_clk);
        i_wen = 1'b1; i_ren = 1'b0; i_funct3 = f3; i_addr = addr; i_wd = wd; i_bus_gnt = 1'b1;
        #1 chk({tag, "_stall_idle"}, 32'(o_stall), 32'd1);
        @(negedge i_clk); #1;
        chk({tag, "_req"}, 32'(o_bus_req), 32'd1);
        chk({tag, "_we"}, 32'(o_bus_we), 32'd1);
        chk({tag, "_be"}, 32'(o_bus_be), 32'(exp_be));
        chk({tag, "_wdata"}, o_bus_wdata, exp_wdata);
        chk({tag, "_addr"}, o_bus_addr, exp_addr);
        chk({tag, "_stall_req"}, 32'(o_stall), 32'd1);
        @(negedge i_clk); #1;
        chk({tag, "_stall_done"}, 32'(o_stall), 32'd0);
        chk({tag, "_req_done"}, 32'(o_bus_req), 32'd0);
        @(negedge i_clk);
        i_wen = 1'b0; i_bus_gnt = 1'b0;
    endtask

    // Load with gnt in REQ and rvalid in the following cycle: IDLE, REQ, WAIT_R, DONE.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_rd);
        @(negedge i_clk);
        i_ren = 1'b1; i_wen = 1'b0; i_funct3 = f3; i_addr = addr;
        #1 chk({tag, "_stall_idle"}, 32'(o_stall), 32'd1);
        @(negedge i_clk);
        i_bus_gnt = 1'b1;
        #1;
        chk({tag, "_req"}, 32'(o_bus_req), 32'd1);
        chk({tag, "_we"}, 32'(o_bus_we), 32'd0);
        chk({tag, "_be"}, 32'(o_bus_be), 32'(exp_be));
        chk({tag, "_addr"}, o_bus_addr, {addr[31:2], 2'b00});
        @(negedge i_clk);
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = rdata;
        #1;
        chk({tag, "_req_wait"}, 32'(o_bus_req), 32'd0);
        chk({tag, "_stall_wait"}, 32'(o_stall), 32'd1);
        @(negedge i_clk);
        i_bus_rvalid = 1'b0;
        #1;
        chk({tag, "_rd"}, o_rd, exp_rd);
        chk({tag, "_stall_done"}, 32'(o_stall), 32'd0);
        @(negedge i_clk);
        i_ren = 1'b0;
    endtask

    initial begin
        int  stall_cycles;
        logic seen_done;

        // Reset state; stall follows the request while in reset.
        #2;
        chk("rst_rd", o_rd, 32'd0);
        chk("rst_req", 32'(o_bus_req), 32'd0);
        chk("rst_be", 32'(o_bus_be), 32'd0);
        chk("rst_addr", o_bus_addr, 32'd0);
        chk("rst_mis", 32'(o_misaligned), 32'd0);
        chk("rst_err", 32'(o_bus_err), 32'd0);
        i_ren = 1'b1;
        #1 chk("rst_stall_ren", 32'(o_stall), 32'd1);
        i_ren = 1'b0;
        #1 chk("rst_stall_idle", 32'(o_stall), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;

        // Stores.
        do_store("sb", F3_LB, 32'h0000_0103, 32'hAABB_CCDD, 4'b1000, 32'hDDDD_DDDD, 32'h0000_0100);
        do_store("sh", F3_LH, 32'h0000_0102, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 32'h0000_0100);
        do_store("sw", F3_LW, 32'h0000_0200, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0000_0200);

        // Loads with sign/zero extension.
        do_load("lh",  F3_LH,  32'h0000_0102, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
        do_load("lhu", F3_LHU, 32'h0000_0102, 32'h8001_1234, 4'b1100, 32'h0000_8001);
        do_load("lw",  F3_LW,  32'h0000_0204, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        // Misaligned word load: one stalled cycle, no bus request, o_rd cleared.
        @(negedge i_clk);
        i_ren = 1'b1; i_funct3 = F3_LW; i_addr = 32'h0000_0205;
        #1 chk("mis_stall_idle", 32'(o_stall), 32'd1);
        @(negedge i_clk); #1;
        chk("mis_pulse", 32'(o_misaligned), 32'd1);
        chk("mis_req", 32'(o_bus_req), 32'd0);
        chk("mis_stall_done", 32'(o_stall), 32'd0);
        chk("mis_rd", o_rd, 32'd0);
        @(negedge i_clk);
        i_ren = 1'b0;
        #1 chk("mis_pulse_end", 32'(o_misaligned), 32'd0);

        // Signed byte load from lane 1.
        do_load("lb", F3_LB, 32'h0000_0101, 32'h1122_B344, 4'b0010, 32'hFFFF_FFB3);

        // Reset while waiting for read data.
        @(negedge i_clk);
        i_ren = 1'b1; i_funct3 = F3_LW; i_addr = 32'h0000_0400;
        @(negedge i_clk);
        i_bus_gnt = 1'b1;
        #1 chk("rw_req", 32'(o_bus_req), 32'd1);
        @(negedge i_clk);
        i_bus_gnt = 1'b0;
        #1 i_rstn = 1'b0;
        #1;
        chk("rw_rd", o_rd, 32'd0);
        chk("rw_bus_addr", o_bus_addr, 32'd0);
        chk("rw_be", 32'(o_bus_be), 32'd0);
        chk("rw_stall", 32'(o_stall), 32'd1);
        i_ren = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        i_bus_rvalid = 1'b0;
        #1;
        chk("late_rvalid_rd", o_rd, 32'd0);
        chk("late_rvalid_req", 32'(o_bus_req), 32'd0);
        do_load("lb_after_rst", F3_LB, 32'h0000_0102, 32'h0077_0000, 4'b0100, 32'h0000_0077);

        // Timeout: gnt in REQ, rvalid never arrives.
        @(negedge i_clk);
        i_ren = 1'b1; i_funct3 = F3_LW; i_addr = 32'h0000_0300;
        #1 chk("to_stall_idle", 32'(o_stall), 32'd1);
        stall_cycles = 1;
        seen_done = 1'b0;
        for (int k = 1; k < 40 && !seen_done; k++) begin
            @(negedge i_clk);
            i_bus_gnt = (k == 1);
            #1;
            if (!o_stall) seen_done = 1'b1;
            else stall_cycles++;
        end
        chk("to_reached_done", 32'(seen_done), 32'd1);
        chk("to_stall_cycles", 32'(stall_cycles), 32'd16);
        chk("to_err", 32'(o_bus_err), 32'd1);
        chk("to_rd", o_rd, 32'd0);
        chk("to_req", 32'(o_bus_req), 32'd0);
        @(negedge i_clk);
        i_ren = 1'b0; i_bus_gnt = 1'b0;
        #1 chk("to_err_end", 32'(o_bus_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
